// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    // Power-on period and high time (the legacy divide-by-120, 50 % duty).
    localparam int DIV_RST  = 120;
    localparam int HIGH_RST = 60;

    // Ceiling log2 for positive values; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

    // Width of the channel-select field; never narrower than one bit.
    function automatic int idx_w(input int ch);
        return (ch > 1) ? clog2(ch) : 1;
    endfunction

    // Default channel count and the matching channel-index width.
    localparam int CH_DEF   = 2;
    localparam int CH_IDX_W = idx_w(CH_DEF);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow configuration,
// pending flag and registered clock/tick decode.
module clk_div_chan #(
    parameter int CNT_W    = 16,
    parameter int DIV_RST  = clk_div_pkg::DIV_RST,
    parameter int HIGH_RST = clk_div_pkg::HIGH_RST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic [CNT_W-1:0] wr_high_i,
    output logic             pending_o,
    output logic             clk_o,
    output logic             tick_o
);
    import clk_div_pkg::*;

    localparam logic [CNT_W-1:0] DIV_RST_V  = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] HIGH_RST_V = CNT_W'(HIGH_RST);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic             wrap;
    logic             restart;
    logic             apply;
    logic [CNT_W:0]   hi_sum;

    // Next-state logic: counting, shadow capture, boundary apply and decode.
    always_comb begin
        wrap    = (cnt_q == div_q - 1'b1);
        // A sync pulse on the wrap cycle is just the ordinary wrap.
        restart = en_i && (wrap || sync_i);
        // Shadow moves to active only at a period boundary, or at once while
        // the channel is idle. The write port is gated by ~pend_q upstream,
        // so a write and an apply never land on the same edge.
        apply   = pend_q && (restart || !en_i);

        cnt_d     = (!en_i || restart) ? '0 : cnt_q + 1'b1;
        div_d     = apply ? sh_div_q  : div_q;
        high_d    = apply ? sh_high_q : high_q;
        sh_div_d  = wr_i  ? wr_div_i  : sh_div_q;
        sh_high_d = wr_i  ? wr_high_i : sh_high_q;
        pend_d    = wr_i || (pend_q && !apply);

        // cnt >= div-high, rearranged as cnt+high >= div in one extra bit so
        // high > div cannot underflow; it simply reads as constant high.
        hi_sum = {1'b0, cnt_q} + {1'b0, high_q};
        clk_d  = en_i && (hi_sum >= {1'b0, div_q});
        tick_d = en_i && wrap;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= DIV_RST_V;
            high_q    <= HIGH_RST_V;
            sh_div_q  <= DIV_RST_V;
            sh_high_q <= HIGH_RST_V;
            pend_q    <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            high_q    <= high_d;
            sh_div_q  <= sh_div_d;
            sh_high_q <= sh_high_d;
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign pending_o = pend_q;
    assign clk_o     = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: configuration handshake,
// reject flag and CH independent divider channels.
module clk_div_multi #(
    parameter int CH       = clk_div_pkg::CH_DEF,
    parameter int CNT_W    = 16,
    parameter int DIV_RST  = clk_div_pkg::DIV_RST,
    parameter int HIGH_RST = clk_div_pkg::HIGH_RST
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [CH-1:0]                       en,
    input  logic                                sync_i,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [clk_div_pkg::idx_w(CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]                    cfg_div,
    input  logic [CNT_W-1:0]                    cfg_high,
    output logic                                cfg_err,
    output logic [CH-1:0]                       clk_o,
    output logic [CH-1:0]                       tick_o
);
    import clk_div_pkg::*;

    localparam int CH_W = idx_w(CH);

    logic [CH-1:0] pend;
    logic [CH-1:0] wr;
    logic          xfer;
    logic          div_ok;
    logic          err_q, err_d;

    // Ready mirrors the selected channel's free shadow; unused codes never accept.
    always_comb begin
        cfg_ready = 1'b0;
        if (32'(cfg_ch) < CH) begin
            cfg_ready = ~pend[cfg_ch];
        end
    end

    // Handshake qualification: a divisor below 2 is consumed but rejected.
    always_comb begin
        xfer   = cfg_valid && cfg_ready;
        div_ok = (cfg_div >= CNT_W'(2));
        err_d  = xfer && !div_ok;
    end

    // Reject flag, one cycle after the offending transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_chan
            assign wr[gi] = xfer && div_ok && (cfg_ch == CH_W'(gi));

            clk_div_chan #(
                .CNT_W    (CNT_W),
                .DIV_RST  (DIV_RST),
                .HIGH_RST (HIGH_RST)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .en_i      (en[gi]),
                .sync_i    (sync_i),
                .wr_i      (wr[gi]),
                .wr_div_i  (cfg_div),
                .wr_high_i (cfg_high),
                .pending_o (pend[gi]),
                .clk_o     (clk_o[gi]),
                .tick_o    (tick_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: the stimulus process queues the
// expected tick cycle and high-time of every period (and every cfg_err
// pulse); a negedge monitor pops and compares whenever the DUT pulses.
module tb_clk_div_multi;

    typedef struct {
        int cyc;
        int hi;
    } tick_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  en = 2'b00;
    logic        sync_i = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [0:0]  cfg_ch = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_high = '0;
    logic        cfg_err;
    logic [1:0]  clk_o;
    logic [1:0]  tick_o;

    int    errors = 0;
    int    checks = 0;
    int    cyc;
    tick_t exp_q[2][$];
    int    err_q[$];
    int    hi_cnt[2];
    logic  sync_prev;

    clk_div_multi dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync_i    (sync_i),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
        .clk_o     (clk_o),
        .tick_o    (tick_o)
    );

    always #10 clk = ~clk;

    // Cycle index: number of rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ticks(input int ch, input int first, input int last,
                              input int stride, input int hi);
        for (int t = first; t <= last; t += stride) begin
            exp_q[ch].push_back('{cyc: t, hi: hi});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            step();
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, n);
        end
    endtask

    task automatic cfg_write(input int ch, input int dv, input int hi);
        cfg_ch    = 1'(ch);
        cfg_div   = 16'(dv);
        cfg_high  = 16'(hi);
        cfg_valid = 1'b1;
        #1;
        check($sformatf("cfg_ready_before_write ch%0d", ch), int'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        $display("cycle %0d: cfg write ch%0d div=%0d high=%0d", cyc - 1, ch, dv, hi);
    endtask

    // Monitor: measure each period's high time and compare at every tick.
    always @(negedge clk) begin
        tick_t e;
        if (!rst_n) begin
            hi_cnt[0] = 0;
            hi_cnt[1] = 0;
            sync_prev = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (clk_o[c]) hi_cnt[c]++;
                if (tick_o[c]) begin
                    if (exp_q[c].size() == 0) begin
                        check($sformatf("tick%0d_unexpected", c), cyc, -1);
                    end else begin
                        e = exp_q[c].pop_front();
                        $display("cycle %0d: tick ch%0d high=%0d (expect cycle %0d high %0d)",
                                 cyc, c, hi_cnt[c], e.cyc, e.hi);
                        check($sformatf("tick%0d_cycle", c), cyc, e.cyc);
                        check($sformatf("tick%0d_high_time", c), hi_cnt[c], e.hi);
                        check($sformatf("tick%0d_last_level", c), int'(clk_o[c]), (e.hi > 0) ? 1 : 0);
                    end
                    hi_cnt[c] = 0;
                end
                // Disabled or sync-truncated periods do not carry into the next.
                if (!en[c] || sync_prev) hi_cnt[c] = 0;
            end
            sync_prev = sync_i;
            if (cfg_err) begin
                if (err_q.size() == 0) begin
                    check("cfg_err_unexpected", cyc, -1);
                end else begin
                    $display("cycle %0d: cfg_err pulse", cyc);
                    check("cfg_err_cycle", cyc, err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 2'b11;
        repeat (3) step();
        check("reset_clk_o", int'(clk_o), 0);
        check("reset_tick_o", int'(tick_o), 0);
        check("reset_cfg_err", int'(cfg_err), 0);
        check("reset_cfg_ready", int'(cfg_ready), 1);

        // ch0: defaults, then div 8 / high 4 from the wrap at 240, a gap while
        // disabled (262..267), then resynchronised at 294.
        push_ticks(0, 120, 240, 120, 60);
        push_ticks(0, 248, 256, 8, 4);
        push_ticks(0, 275, 291, 8, 4);
        push_ticks(0, 302, 318, 8, 4);
        // ch1: defaults, 10/3 from 120, 10/0 from 150, 10/12 from 170,
        // 8/4 from 200 (written on the 190 wrap), resynchronised at 294.
        push_ticks(1, 120, 120, 1, 60);
        push_ticks(1, 130, 150, 10, 3);
        push_ticks(1, 160, 170, 10, 0);
        push_ticks(1, 180, 200, 10, 10);
        push_ticks(1, 208, 288, 8, 4);
        push_ticks(1, 302, 318, 8, 4);
        err_q.push_back(133);

        rst_n = 1'b1;

        // Mid-period reconfigure of ch1 at cnt = 40.
        wait_cyc(40);
        cfg_write(1, 10, 3);
        cfg_ch = 1'b1;
        #1 check("ch1_ready_after_write", int'(cfg_ready), 0);
        wait_cyc(119);
        check("ch1_ready_before_wrap", int'(cfg_ready), 0);
        wait_cyc(120);
        check("ch1_ready_after_wrap", int'(cfg_ready), 1);

        // Rejected divisor, then the high-time boundaries.
        wait_cyc(132);
        cfg_write(1, 1, 5);
        cfg_ch = 1'b1;
        #1 check("ch1_ready_after_reject", int'(cfg_ready), 1);
        wait_cyc(142);
        cfg_write(1, 10, 0);
        cfg_ch = 1'b1;
        #1 check("ch1_ready_high0_pending", int'(cfg_ready), 0);
        wait_cyc(162);
        cfg_write(1, 10, 12);

        // Write landing on the wrap edge at 190 waits for the wrap at 200.
        wait_cyc(189);
        cfg_write(1, 8, 4);
        cfg_ch = 1'b1;
        wait_cyc(199);
        check("ch1_ready_wrapwrite_pending", int'(cfg_ready), 0);
        wait_cyc(200);
        check("ch1_ready_wrapwrite_applied", int'(cfg_ready), 1);

        wait_cyc(205);
        cfg_write(0, 8, 4);

        // Disable ch0 while its output is high.
        wait_cyc(262);
        check("ch0_high_before_disable", int'(clk_o[0]), 1);
        en[0] = 1'b0;
        step();
        check("ch0_low_after_disable", int'(clk_o[0]), 0);
        wait_cyc(267);
        en[0] = 1'b1;

        // Phase sync: ch0 runs 3 cycles behind ch1 until the pulse.
        wait_cyc(293);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        $display("cycle %0d: sync pulse applied", cyc);

        // Leave ch1 pending, then reset mid-period.
        wait_cyc(320);
        cfg_write(1, 20, 5);
        cfg_ch = 1'b1;
        #1 check("ch1_ready_pending_before_reset", int'(cfg_ready), 0);
        wait_cyc(323);
        check("clk_o_high_before_reset", int'(clk_o), 3);
        rst_n = 1'b0;
        #1;
        check("reset_mid_clk_o", int'(clk_o), 0);
        check("reset_mid_tick_o", int'(tick_o), 0);
        check("reset_mid_cfg_ready", int'(cfg_ready), 1);
        check("reset_mid_cfg_err", int'(cfg_err), 0);
        check("queue0_drained_before_reset", exp_q[0].size(), 0);
        check("queue1_drained_before_reset", exp_q[1].size(), 0);
        step();
        step();
        push_ticks(0, 120, 120, 1, 60);
        push_ticks(1, 120, 120, 1, 60);
        rst_n = 1'b1;
        wait_cyc(125);

        check("queue0_empty", exp_q[0].size(), 0);
        check("queue1_empty", exp_q[1].size(), 0);
        check("err_queue_empty", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel programmable clock divider and the successor to the team's fixed divide-by-120 generator. From the 50 MHz system clock it produces CH independent divided outputs, each with a runtime-programmable period and high time, plus a one-cycle tick per period for use as a clock enable. Configuration uses a valid/ready handshake, and new values take effect only at a period boundary, so outputs never glitch. It sits beside the key-scan and sequence-detector logic and feeds their sampling strobes.

## Interface
- CH, 2: number of output channels, 1..8.
- CNT_W, 16: counter and divisor width in bits.
- DIV_RST, 120: divisor loaded into every channel at reset; must be ≥ 2.
- HIGH_RST, 60: high time loaded into every channel at reset.
- clk  in  1: system clock, 50 MHz. One clock, all logic on its rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- en  in  CH: per-channel run enable.
- sync_i  in  1: single-cycle phase-align pulse for all channels.
- cfg_valid  in  1: configuration request.
- cfg_ready  out  1: configuration accept, equal to ~pending[cfg_ch], combinational.
- cfg_ch  in  clog2(CH) (min 1): target channel.
- cfg_div  in  CNT_W: new period in clk cycles.
- cfg_high  in  CNT_W: new high time in clk cycles.
- cfg_err  out  1: one-cycle pulse when a handshake carried cfg_div < 2.
- clk_o  out  CH: divided square outputs.
- tick_o  out  CH: one-cycle pulse per period.

## Operation
- Each channel has:
  - an active register pair: div, high;
  - a shadow register pair;
  - a pending flag;
  - a counter cnt in 0..div-1.
- Reset values: cnt = 0; active and shadow registers = DIV_RST/HIGH_RST; pending = 0; clk_o = 0; tick_o = 0; cfg_err = 0.
- Run (en[i] = 1): cnt increments each cycle and wraps from div-1 to 0.
- Disabled (en[i] = 0): cnt is held at 0, clk_o[i] = 0, tick_o[i] = 0. After en rises, the first period starts at cnt = 0.
- Output decode, all registered from the current cnt:
  - clk_o[i] = 1 when cnt ≥ div-high. The period is low first, then high.
  - high = 0 gives a constant-low clk_o. high ≥ div gives a constant-high clk_o.
  - tick_o[i] = 1 when cnt = div-1.
- Configuration handshake: a transfer occurs when cfg_valid && cfg_ready.
  - cfg_div ≥ 2: the shadow registers are written and pending is set.
  - cfg_div < 2: the transfer is rejected, registers are unchanged, and cfg_err pulses the next cycle.
- Apply: on a wrap cycle (cnt = div-1 → 0) with pending already set, active ← shadow and pending is cleared. The new period starts at cnt = 0.
  - A transfer in the same cycle as a wrap applies at the following wrap.
  - With en[i] = 0, a pending update applies on the next cycle.
- sync_i: every enabled channel forces cnt to 0 on the next edge. Pending updates apply in that same cycle. tick_o is not asserted for a truncated period.
- sync_i coinciding with a wrap behaves as a plain wrap.
- Arithmetic: the comparison div-high is performed in CNT_W+1 bits, so there is no wrap-around error when high > div.

## Timing
- clk_o and tick_o lag the cnt value they decode by one cycle. At the defaults, clk_o is low for 60 cycles, then high for 60 cycles, period 120.
- cfg_ready is combinational from cfg_ch and pending.
- Handshake to active update: at most div+1 cycles later.
- cfg_err: 1 cycle after the rejected transfer.
- When rst_n is asserted mid-operation, every output clears immediately. The first period after release starts with cnt = 0.

## Structure
- clk_div_pkg holds:
  - reset constants DIV_RST and HIGH_RST;
  - a clog2 function;
  - the channel-index width, as a localparam derived from CH.
- Sub-module clk_div_chan contains one channel: counter, active/shadow/pending registers, and decode.
  - The top level instantiates it CH times through a generate loop.
  - The top level owns the cfg_ch decode, the cfg_ready mux and cfg_err.

## Test plan
- Reset release, en = 2'b11, defaults:
  - clk_o[0] is low for 60 cycles, then high for 60, repeating.
  - tick_o[0] asserts every 120 cycles.
- Reconfigure mid-period: write ch1 div = 10, high = 3 at cnt = 40.
  - cfg_ready[ch1] drops.
  - The old period completes.
  - The next period is 7 low, 3 high.
  - pending clears at the wrap.
- Boundaries:
  - cfg_div = 1 → cfg_err pulse, no change.
  - high = 0 → clk_o constant 0.
  - high = 12 with div = 10 → clk_o constant 1.
  - tick_o continues at period 10 in every case.
- Write coinciding with the wrap cycle → applied one period later, not immediately.
- Phase sync:
  - ch0 div = 8, ch1 div = 8, started 3 cycles apart.
  - Pulse sync_i → both tick_o coincide thereafter.
  - No tick_o for the truncated period.
- Control interruptions:
  - Deassert en[0] mid-period → clk_o[0] = 0 on the next cycle, and the period restarts cleanly on re-enable.
  - Assert rst_n = 0 mid-period → all outputs clear immediately and the registers return to 120/60.
